proc_datapath: RTL

- Register/bus datapath of the multi-cycle processor, directly downstream of the control unit.
- Consumes the unit's strobes (IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub) and returns IRout plus the decoded X/Y one-hot selects.
- Holds R0..R7, A, G and IR; drives the shared bus; computes ALU results for add/sub/slt/sll/slr/and.

---
 rtl/proc_datapath_pkg.sv | 22 ++
 rtl/proc_alu.sv | 32 +++
 rtl/proc_datapath.sv | 97 +++++++++
 3 files changed

// File: rtl/proc_datapath_pkg.sv
// rtl/proc_datapath_pkg.sv - opcodes, IR field positions and register count shared with the control unit
package proc_datapath_pkg;

  localparam int NREGS = 8;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] SLT = 3'b010;
  localparam logic [2:0] SLL = 3'b011;
  localparam logic [2:0] SLR = 3'b100;
  localparam logic [2:0] AND = 3'b101;
  localparam logic [2:0] MV  = 3'b110;
  localparam logic [2:0] MVI = 3'b111;

  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int X_HI  = 5;
  localparam int X_LO  = 3;
  localparam int Y_HI  = 2;
  localparam int Y_LO  = 0;

endpackage

// File: rtl/proc_alu.sv
// rtl/proc_alu.sv - combinational ALU for add/sub/slt/sll/slr/and/mv/mvi
module proc_alu
  import proc_datapath_pkg::*;
#(
  parameter int DW  = 16,
  parameter int SHW = 4
) (
  input  logic [2:0]    op,
  input  logic          AddSub,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] Bus,
  output logic [DW-1:0] result
);

  logic lt;

  assign lt = $signed(A) < $signed(Bus);

  always_comb begin
    result = Bus;
    case (op)
      // add and sub share one adder; AddSub alone picks the direction
      ADD, SUB: result = AddSub ? (A - Bus) : (A + Bus);
      SLT:      result = {{(DW-1){1'b0}}, lt};
      SLL:      result = A << Bus[SHW-1:0];
      SLR:      result = A >> Bus[SHW-1:0];
      AND:      result = A & Bus;
      default:  result = Bus;
    endcase
  end

endmodule

// File: rtl/proc_datapath.sv
// rtl/proc_datapath.sv - register file, shared bus, IR and ALU wrapper of the multi-cycle processor
// Optional multi-driver detection on the bus: PROC_DATAPATH_BUS_CONFLICT_EN
module proc_datapath
  import proc_datapath_pkg::*;
#(
  parameter int DW  = 16,
  parameter int SHW = 4
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic [DW-1:0]    DIN,
  input  logic             IRin,
  input  logic [NREGS-1:0] Rin,
  input  logic [NREGS-1:0] Rout,
  input  logic             Ain,
  input  logic             Gin,
  input  logic             Gout,
  input  logic             DINout,
  input  logic             AddSub,
  output logic [9:0]       IRout,
  output logic [7:0]       Xsel,
  output logic [7:0]       Ysel,
  output logic [DW-1:0]    BusWires,
  output logic             BusErr
);

  logic [DW-1:0] regs [NREGS];
  logic [DW-1:0] a_reg;
  logic [DW-1:0] g_reg;
  logic [9:0]    ir;
  logic [DW-1:0] alu_result;

  // Descending scan so the lowest enabled Rout index is the one left standing
  always_comb begin
    BusWires = '0;
    if (Gout) begin
      BusWires = g_reg;
    end else if (DINout) begin
      BusWires = DIN;
    end else begin
      for (int i = NREGS - 1; i >= 0; i--) begin
        if (Rout[i]) BusWires = regs[i];
      end
    end
  end

  proc_alu #(
    .DW  (DW),
    .SHW (SHW)
  ) u_alu (
    .op     (ir[OP_HI:OP_LO]),
    .AddSub (AddSub),
    .A      (a_reg),
    .Bus    (BusWires),
    .result (alu_result)
  );

  always_ff @(posedge clock) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      a_reg <= '0;
      g_reg <= '0;
      ir    <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (Rin[i]) regs[i] <= BusWires;
      end
      if (Ain)  a_reg <= BusWires;
      if (Gin)  g_reg <= alu_result;
      if (IRin) ir    <= DIN[9:0];
    end
  end

  assign IRout = ir;
  assign Xsel  = 8'b1 << ir[X_HI:X_LO];
  assign Ysel  = 8'b1 << ir[Y_HI:Y_LO];

`ifdef PROC_DATAPATH_BUS_CONFLICT_EN
  logic [3:0] nsrc;
  logic       bus_err_q;

  assign nsrc = 4'(Gout) + 4'(DINout) + 4'($countones(Rout));

  always_ff @(posedge clock) begin
    if (Reset) begin
      bus_err_q <= 1'b0;
    end else if (nsrc > 4'd1) begin
      bus_err_q <= 1'b1;
    end
  end

  assign BusErr = bus_err_q;
`else
  assign BusErr = 1'b0;
`endif

endmodule
